// File: rtl/sysarr_pkg.sv
// rtl/sysarr_pkg.sv - shared types and helpers for the sparse systolic array FIFO
package sysarr_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int IDX_W_DEF  = 8;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] val;
    logic [IDX_W_DEF-1:0]  ind;
    logic                  last;
  } sparse_entry_t;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sysarr_sparse_fifo_if.sv
// rtl/sysarr_sparse_fifo_if.sv - flattened per-lane push/pop buses of the sparse FIFO
interface sysarr_sparse_fifo_if
  import sysarr_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 8,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = occ_width(DEPTH);

  logic [LANES-1:0]        push_valid;
  logic [LANES-1:0]        push_ready;
  logic [LANES*DATA_W-1:0] push_val;
  logic [LANES*IDX_W-1:0]  push_ind;
  logic [LANES-1:0]        push_last;
  logic [LANES-1:0]        pop_ready;
  logic [LANES-1:0]        pop_valid;
  logic [LANES*DATA_W-1:0] pop_val;
  logic [LANES*IDX_W-1:0]  pop_ind;
  logic [LANES-1:0]        pop_last;
  logic [LANES*CNT_W-1:0]  count;
  logic [LANES*CNT_W-1:0]  rows_avail;

  modport master (
    output push_valid, push_val, push_ind, push_last, pop_ready,
    input  push_ready, pop_valid, pop_val, pop_ind, pop_last, count, rows_avail
  );

  modport slave (
    input  push_valid, push_val, push_ind, push_last, pop_ready,
    output push_ready, pop_valid, pop_val, pop_ind, pop_last, count, rows_avail
  );

endinterface

// File: rtl/sysarr_sparse_fifo_lane.sv
// rtl/sysarr_sparse_fifo_lane.sv - one independent FWFT lane with occupancy, row count and zero skip
module sysarr_sparse_fifo_lane
  import sysarr_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int IDX_W     = 8,
  parameter int DEPTH     = 8,
  parameter int SKIP_ZERO = 0,
  parameter int CNT_W     = occ_width(DEPTH)
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              flush_i,
  input  logic              push_valid_i,
  output logic              push_ready_o,
  input  logic [DATA_W-1:0] push_val_i,
  input  logic [IDX_W-1:0]  push_ind_i,
  input  logic              push_last_i,
  input  logic              pop_ready_i,
  output logic              pop_valid_o,
  output logic [DATA_W-1:0] pop_val_o,
  output logic [IDX_W-1:0]  pop_ind_o,
  output logic              pop_last_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [CNT_W-1:0]  rows_avail_o
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic [IDX_W-1:0]  ind;
    logic              last;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, rows_q, rows_d;
  logic             push_fire, pop_fire, skip, store;

  assign push_ready_o = (count_q != CNT_W'(DEPTH));
  assign pop_valid_o  = (count_q != '0);
  assign push_fire    = push_valid_i && push_ready_o;
  assign pop_fire     = pop_valid_o && pop_ready_i;
  // Zero non-terminal entries are handshaken but dropped; a zero row-end still marks the boundary.
  assign skip         = (SKIP_ZERO != 0) && (push_val_i == '0) && !push_last_i;
  assign store        = push_fire && !skip;

  assign head         = mem_q[rd_ptr_q];
  assign pop_val_o    = pop_valid_o ? head.val  : '0;
  assign pop_ind_o    = pop_valid_o ? head.ind  : '0;
  assign pop_last_o   = pop_valid_o && head.last;
  assign count_o      = count_q;
  assign rows_avail_o = rows_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rows_d   = rows_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      rows_d   = '0;
    end else begin
      if (store)    wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(store) - CNT_W'(pop_fire);
      rows_d  = rows_q + CNT_W'(store && push_last_i) - CNT_W'(pop_fire && head.last);
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rows_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rows_q   <= rows_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store && !flush_i) mem_q[wr_ptr_q] <= '{val: push_val_i, ind: push_ind_i, last: push_last_i};
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!nRST)
    !(store && count_q == CNT_W'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!nRST)
    !(pop_fire && count_q == '0));

endmodule

// File: rtl/sysarr_sparse_fifo.sv
// rtl/sysarr_sparse_fifo.sv - multi-lane value/index FIFO feeding the sparse systolic array rows
module sysarr_sparse_fifo
  import sysarr_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int DATA_W    = 16,
  parameter int IDX_W     = 8,
  parameter int DEPTH     = 8,
  parameter int SKIP_ZERO = 0
) (
  input logic                clk,
  input logic                nRST,
  input logic                flush,
  sysarr_sparse_fifo_if.slave bus
);
  localparam int CNT_W = occ_width(DEPTH);

  logic [LANES-1:0]  push_ready_w, pop_valid_w, pop_last_w;
  logic [DATA_W-1:0] pop_val_w  [LANES];
  logic [IDX_W-1:0]  pop_ind_w  [LANES];
  logic [CNT_W-1:0]  count_w    [LANES];
  logic [CNT_W-1:0]  rows_w     [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sysarr_sparse_fifo_lane #(
      .DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH(DEPTH), .SKIP_ZERO(SKIP_ZERO), .CNT_W(CNT_W)
    ) u_lane (
      .clk          (clk),
      .nRST         (nRST),
      .flush_i      (flush),
      .push_valid_i (bus.push_valid[l]),
      .push_ready_o (push_ready_w[l]),
      .push_val_i   (bus.push_val[l*DATA_W +: DATA_W]),
      .push_ind_i   (bus.push_ind[l*IDX_W +: IDX_W]),
      .push_last_i  (bus.push_last[l]),
      .pop_ready_i  (bus.pop_ready[l]),
      .pop_valid_o  (pop_valid_w[l]),
      .pop_val_o    (pop_val_w[l]),
      .pop_ind_o    (pop_ind_w[l]),
      .pop_last_o   (pop_last_w[l]),
      .count_o      (count_w[l]),
      .rows_avail_o (rows_w[l])
    );
  end

  assign bus.push_ready = push_ready_w;
  assign bus.pop_valid  = pop_valid_w;
  assign bus.pop_last   = pop_last_w;

  always_comb begin
    bus.pop_val    = '0;
    bus.pop_ind    = '0;
    bus.count      = '0;
    bus.rows_avail = '0;
    for (int l = 0; l < LANES; l++) begin
      bus.pop_val[l*DATA_W +: DATA_W]   = pop_val_w[l];
      bus.pop_ind[l*IDX_W +: IDX_W]     = pop_ind_w[l];
      bus.count[l*CNT_W +: CNT_W]       = count_w[l];
      bus.rows_avail[l*CNT_W +: CNT_W]  = rows_w[l];
    end
  end

endmodule

// File: tb/tb_sysarr_sparse_fifo.sv
// tb/tb_sysarr_sparse_fifo.sv - directed and randomized bench for sysarr_sparse_fifo
module tb_sysarr_sparse_fifo;
  import sysarr_pkg::*;

  localparam int LANES  = 4;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 8;
  localparam int DEPTH  = 8;
  localparam int CW     = occ_width(DEPTH);

  logic clk = 1'b0;
  logic nRST;
  logic flush;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  sysarr_sparse_fifo_if #(.LANES(LANES), .DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH(DEPTH)) bus ();

  sysarr_sparse_fifo #(
    .LANES(LANES), .DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH(DEPTH), .SKIP_ZERO(1)
  ) dut (
    .clk   (clk),
    .nRST  (nRST),
    .flush (flush),
    .bus   (bus)
  );

  // Reference: each lane is just an ordered queue of stored entries.
  sparse_entry_t mq [LANES][$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int rows_of(input int l);
    int r = 0;
    foreach (mq[l][i]) if (mq[l][i].last) r++;
    return r;
  endfunction

  task automatic check_all();
    for (int l = 0; l < LANES; l++) begin
      sparse_entry_t h = '0;
      int sz = mq[l].size();
      if (sz != 0) h = mq[l][0];
      check($sformatf("push_ready%0d", l), 32'(bus.push_ready[l]), 32'(sz != DEPTH));
      check($sformatf("pop_valid%0d", l),  32'(bus.pop_valid[l]),  32'(sz != 0));
      check($sformatf("pop_val%0d", l),    32'(bus.pop_val[l*DATA_W +: DATA_W]), 32'(h.val));
      check($sformatf("pop_ind%0d", l),    32'(bus.pop_ind[l*IDX_W +: IDX_W]),   32'(h.ind));
      check($sformatf("pop_last%0d", l),   32'(bus.pop_last[l]), 32'(h.last));
      check($sformatf("count%0d", l),      32'(bus.count[l*CW +: CW]), 32'(sz));
      check($sformatf("rows%0d", l),       32'(bus.rows_avail[l*CW +: CW]), 32'(rows_of(l)));
    end
  endtask

  task automatic model_step();
    for (int l = 0; l < LANES; l++) begin
      sparse_entry_t e;
      bit pop_f, push_f;
      if (flush) begin
        mq[l].delete();
      end else begin
        pop_f  = (mq[l].size() != 0) && bus.pop_ready[l];
        push_f = (mq[l].size() != DEPTH) && bus.push_valid[l];
        e.val  = bus.push_val[l*DATA_W +: DATA_W];
        e.ind  = bus.push_ind[l*IDX_W +: IDX_W];
        e.last = bus.push_last[l];
        if (pop_f) void'(mq[l].pop_front());
        if (push_f && !(e.val == 0 && !e.last)) mq[l].push_back(e);
      end
    end
  endtask

  task automatic cycle();
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.push_valid = '0;
    bus.push_val   = '0;
    bus.push_ind   = '0;
    bus.push_last  = '0;
    bus.pop_ready  = '0;
    flush          = 1'b0;
  endtask

  task automatic set_push(input int l, input logic v, input logic [15:0] val,
                          input logic [7:0] ind, input logic last);
    bus.push_valid[l]                = v;
    bus.push_val[l*DATA_W +: DATA_W] = val;
    bus.push_ind[l*IDX_W +: IDX_W]   = ind;
    bus.push_last[l]                 = last;
  endtask

  task automatic drain();
    clear_inputs();
    bus.pop_ready = '1;
    for (int i = 0; i < DEPTH + 1; i++) cycle();
    clear_inputs();
  endtask

  logic [15:0] t1_val [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};

  initial begin
    nRST = 1'b0;
    clear_inputs();
    #12;
    check_all();
    check("rst_push_ready", 32'(bus.push_ready), 32'hF);
    @(negedge clk) nRST = 1'b1;
    @(posedge clk);
    #1;

    // 1: four pushes on lane0, then four pops in order
    for (int i = 0; i < 4; i++) begin
      set_push(0, 1'b1, t1_val[i], 8'(i + 1), i == 3);
      cycle();
    end
    clear_inputs();
    check("t1_count", 32'(bus.count[CW-1:0]), 32'd4);
    check("t1_rows", 32'(bus.rows_avail[CW-1:0]), 32'd1);
    bus.pop_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t1_head_val", 32'(bus.pop_val[15:0]), 32'(t1_val[i]));
      check("t1_head_ind", 32'(bus.pop_ind[7:0]), 32'(i + 1));
      check("t1_head_last", 32'(bus.pop_last[0]), 32'(i == 3));
      cycle();
    end
    clear_inputs();
    check("t1_empty", 32'(bus.pop_valid[0]), 32'd0);
    check("t1_rows0", 32'(bus.rows_avail[CW-1:0]), 32'd0);

    // 2: fill lane1, reject ninth push, pop+push while full
    for (int i = 0; i < DEPTH; i++) begin
      set_push(1, 1'b1, 16'(i + 1), 8'(i), 1'b0);
      cycle();
    end
    check("t2_full_ready", 32'(bus.push_ready[1]), 32'd0);
    set_push(1, 1'b1, 16'h0099, 8'h99, 1'b0);
    cycle();
    check("t2_ninth", 32'(bus.count[CW +: CW]), 32'(DEPTH));
    bus.pop_ready[1] = 1'b1;
    cycle();
    check("t2_pop_full", 32'(bus.count[CW +: CW]), 32'(DEPTH - 1));
    check("t2_ready_back", 32'(bus.push_ready[1]), 32'd1);
    drain();

    // 3: lane2 streaming push+pop, pointers wrap twice
    bus.pop_ready[2] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) check("t3_order", 32'(bus.pop_ind[2*IDX_W +: IDX_W]), 32'(i - 1));
      set_push(2, 1'b1, 16'(i + 1), 8'(i), 1'b0);
      cycle();
      check("t3_count", 32'(bus.count[2*CW +: CW]), 32'd1);
    end
    drain();

    // 4: zero skip on lane3
    for (int i = 0; i < 5; i++) begin
      logic [15:0] v;
      v = (i == 1) ? 16'd5 : (i == 3) ? 16'd7 : 16'd0;
      set_push(3, 1'b1, v, 8'(i), i == 4);
      cycle();
    end
    clear_inputs();
    check("t4_count", 32'(bus.count[3*CW +: CW]), 32'd3);
    check("t4_rows", 32'(bus.rows_avail[3*CW +: CW]), 32'd1);
    check("t4_head", 32'(bus.pop_val[3*DATA_W +: DATA_W]), 32'd5);
    drain();

    // 5: flush overrides a simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) begin
      set_push(0, i < 3, 16'h0100 + 16'(i), 8'(i), 1'b0);
      set_push(2, 1'b1, 16'h0200 + 16'(i), 8'(i), i == 7);
      set_push(3, i < 1, 16'h0300, 8'(i), 1'b1);
      cycle();
    end
    clear_inputs();
    check("t5_pre", 32'(bus.count), 32'h1803);
    flush = 1'b1;
    set_push(1, 1'b1, 16'h0777, 8'h77, 1'b1);
    bus.pop_ready[0] = 1'b1;
    cycle();
    clear_inputs();
    check("t5_counts", 32'(bus.count), 32'd0);
    check("t5_valid", 32'(bus.pop_valid), 32'd0);
    check("t5_ready", 32'(bus.push_ready), 32'hF);

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) begin
      set_push(0, 1'b1, 16'h0500 + 16'(i), 8'(i), i == 2);
      cycle();
    end
    clear_inputs();
    check("t6_pre", 32'(bus.count[CW-1:0]), 32'd5);
    #2 nRST = 1'b0;
    #1;
    for (int l = 0; l < LANES; l++) mq[l].delete();
    check("t6_valid", 32'(bus.pop_valid), 32'd0);
    check("t6_count", 32'(bus.count), 32'd0);
    check("t6_rows", 32'(bus.rows_avail), 32'd0);
    check_all();
    @(negedge clk) nRST = 1'b1;
    @(posedge clk);
    #1;
    set_push(0, 1'b1, 16'hAAAA, 8'h01, 1'b0);
    cycle();
    clear_inputs();
    bus.pop_ready[0] = 1'b1;
    check("t6_aaaa", 32'(bus.pop_val[15:0]), 32'hAAAA);
    cycle();
    clear_inputs();

    // Randomized traffic, with the pop bias changing per phase so lanes both fill and drain
    for (int i = 0; i < 400; i++) begin
      int pop_bias = ((i / 50) % 2 == 0) ? 1 : 3;
      for (int l = 0; l < LANES; l++) begin
        logic [15:0] v;
        v = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
        set_push(l, 1'($urandom_range(0, 1)), v, 8'($urandom), $urandom_range(0, 3) == 0);
        bus.pop_ready[l] = ($urandom_range(0, 3) < pop_bias);
      end
      flush = ($urandom_range(0, 59) == 0);
      cycle();
    end
    clear_inputs();
    check_all();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sysarr_sparse_fifo.md
Name: sysarr_sparse_fifo

Overview:
Multi-lane value/index FIFO feeding the sparse systolic array rows. It is the parametrised successor of the single-lane load/shift FIFO. Each lane is an independent FIFO with a valid/ready handshake on both sides, full/empty and occupancy reporting, and a row-end tag on every entry. An optional zero-skip mode drops zero-valued non-terminal entries on push, so only non-zeros reach the array.

Parameters:
LANES, 4, number of independent channels (one per array row)
DATA_W, 16, value width
IDX_W, 8, index width
DEPTH, 8, entries per lane; power of two, >= 2
SKIP_ZERO, 0, 1 = discard pushes with val==0 && last==0

Ports:
clk  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all lanes
push_valid  in  LANES  per-lane push request
push_ready  out  LANES  per-lane space available
push_val  in  LANES*DATA_W  lane l at bits [l*DATA_W +: DATA_W]
push_ind  in  LANES*IDX_W  lane l at bits [l*IDX_W +: IDX_W]
push_last  in  LANES  entry ends a row
pop_ready  in  LANES  consumer takes head
pop_valid  out  LANES  head entry present
pop_val  out  LANES*DATA_W  head value
pop_ind  out  LANES*IDX_W  head index
pop_last  out  LANES  head row-end tag
count  out  LANES*$clog2(DEPTH+1)  per-lane occupancy
rows_avail  out  LANES*$clog2(DEPTH+1)  stored entries with last=1, per lane

Behaviour:
- Reset (nRST low, async): pointers, count and rows_avail go to 0. pop_valid=0, push_ready=all 1s, and pop_val/ind/last=0. Memory contents are don't-care.
- Lanes are fully independent. No cross-lane ordering exists.
- Push fires when push_valid[l] && push_ready[l] at a rising edge. push_ready[l] = (count[l] != DEPTH), combinational from registered state only. It never depends on pop_ready.
- Pop fires when pop_valid[l] && pop_ready[l]. The head is first-word-fall-through. pop_valid[l] = (count[l] != 0).
- pop_val, pop_ind and pop_last are forced to 0 whenever pop_valid[l]=0.
- Latency: an entry pushed at edge N is visible on pop_* after edge N (pop_valid high in cycle N+1). There is no same-cycle bypass.
- Empty lane with push and pop_ready in the same cycle: the push is stored and nothing is popped.
- Full lane: the push is not accepted. A pop in the same cycle still fires, count goes DEPTH-1, and push_ready rises the next cycle.
- Non-empty, non-full lane with push and pop together: both fire and count is unchanged.
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count disambiguates full from empty.
- SKIP_ZERO=1: a push with val==0 && last==0 is handshaken (push_ready still applies) but not stored. count and pointers are unchanged.
- SKIP_ZERO=1: a push with val==0 && last==1 is stored, so the row boundary survives.
- SKIP_ZERO=0: every accepted push is stored.
- rows_avail[l]: +1 on a stored push with last=1, -1 on a popped entry with last=1. Both in the same cycle leaves it unchanged.
- flush (synchronous): pointers, count and rows_avail go to 0 at the edge. It overrides any simultaneous push or pop, neither of which takes effect.
- Reset asserted mid-operation: all state clears immediately. The first push after release behaves as from a fresh reset.
- Overflow and underflow are impossible by construction. Assertions in the lane check push-when-full-accepted and pop-when-empty-fired never occur.

Decomposition:
- Shared package sysarr_pkg:
  - typedef sparse_entry_t: struct {logic [DATA_W-1:0] val; logic [IDX_W-1:0] ind; logic last;}, parameterised via package localparams with default widths.
  - Function to compute occupancy width.
- Sub-module sysarr_sparse_fifo_lane: one lane (memory, pointers, count, rows_avail, skip logic).
- The top only generates LANES instances and packs/unpacks the flattened buses.

Test Plan:
1. Reset, then lane0 pushes (0x0123,1,0),(0x4567,2,0),(0x89AB,3,0),(0xCDEF,4,1) on consecutive cycles with pop_ready=0 -> count[0]=4, rows_avail[0]=1. Then pop_ready=1 for 4 cycles -> heads 0123/1, 4567/2, 89AB/3, CDEF/4/last=1, then pop_valid=0, count=0, rows_avail=0.
2. Fill lane1 with 8 entries (val=i+1, ind=i) -> push_ready[1]=0. A ninth push is not accepted. Pop and push in the same cycle when full -> only the pop fires, count=7. Next cycle push_ready=1.
3. Steady stream on lane2 with push and pop every cycle for 20 cycles (pointer wraps twice) -> count stays 1 after the first cycle. Output order matches input (ind 0..19) with no loss or duplication.
4. SKIP_ZERO=1: lane3 pushes vals 0,5,0,7,0(last=1) -> stored entries 5,7,0/last=1, count=3, rows_avail=1.
5. Lanes 0-3 partially filled (counts 3,0,8,1). Assert flush with a simultaneous push on lane1 and pop on lane0 -> next cycle all counts 0, all pop_valid=0, push_ready=all 1s.
6. Reset asserted mid-stream with lane0 count=5 -> pop_valid, count and rows_avail go 0 asynchronously. After release, push 0xAAAA -> popped value 0xAAAA.
